// File: rtl/prog_mem_pkg.sv
// Shared definitions for the runtime-loadable program memory: loader states,
// the default fill word and the core opcode constants used by the test images.
// Build option: PROGMEM_CHECKSUM_EN adds the CHECK state.
package prog_mem_pkg;

    typedef enum logic [2:0] {
        ST_EMPTY = 3'd0,
        ST_LOAD  = 3'd1,
`ifdef PROGMEM_CHECKSUM_EN
        ST_CHECK = 3'd2,
`endif
        ST_FILL  = 3'd3,
        ST_RUN   = 3'd4
    } state_t;

    // Core opcodes (8-bit ISA).
    localparam logic [7:0] OP_NOP     = 8'h70;
    localparam logic [7:0] OP_MOV_IMM = 8'h10;
    localparam logic [7:0] OP_CMP_IMM = 8'h18;
    localparam logic [7:0] OP_INC     = 8'h40;
    localparam logic [7:0] OP_SHR     = 8'h48;
    localparam logic [7:0] OP_ADD     = 8'h98;
    localparam logic [7:0] OP_BRA     = 8'hC0;
    localparam logic [7:0] OP_BEQ     = 8'hC8;
    localparam logic [7:0] OP_HLT     = 8'hFF;

    localparam logic [7:0] NOP_WORD_DEF = OP_NOP;

endpackage

// File: rtl/prog_mem_array.sv
// Program storage: DEPTH x DATA_W, one synchronous write port and two
// asynchronous read ports. The second read address is fetch address + 1,
// wrapped modulo DEPTH. No reset: contents are undefined after power-up.
module prog_mem_array #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 8,
    parameter int DEPTH  = 2 ** ADDR_W
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata,
    output logic [DATA_W-1:0] rdata_next
);

    localparam logic [ADDR_W:0] LAST_ADDR = (ADDR_W + 1)'(DEPTH - 1);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [ADDR_W-1:0] raddr_next;

    // Single write port; a same-cycle read sees the old word.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Wrapped address for the second fetch byte.
    always_comb begin
        raddr_next = raddr + 1'b1;
        if ({1'b0, raddr} == LAST_ADDR) begin
            raddr_next = '0;
        end
    end

    assign rdata      = mem[raddr];
    assign rdata_next = mem[raddr_next];

endmodule

// File: rtl/prog_mem_loader.sv
// Runtime-loadable instruction memory with byte-serial load port, NOP
// back-fill and CPU hold until a complete program is in place.
// Build option: PROGMEM_CHECKSUM_EN appends a checksum byte to each load.
//
// state | meaning
// EMPTY | no valid program; CPU held, waiting for load_start
// LOAD  | accepting program bytes into mem[wr_ptr]
// CHECK | accepting the checksum byte (checksum build only)
// FILL  | writing NOP_WORD into words len..DEPTH-1
// RUN   | program valid; CPU released, load_start starts a reload
module prog_mem_loader
    import prog_mem_pkg::*;
#(
    parameter int                DATA_W   = 8,
    parameter int                ADDR_W   = 8,
    parameter int                DEPTH    = 2 ** ADDR_W,
    parameter logic [DATA_W-1:0] NOP_WORD = DATA_W'(NOP_WORD_DEF)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load_start,
    input  logic [ADDR_W:0]   load_len,
    input  logic              ld_valid,
    input  logic [DATA_W-1:0] ld_data,
    output logic              ld_ready,
    input  logic [ADDR_W-1:0] fetch_addr,
    output logic [DATA_W-1:0] fetch_data,
    output logic [DATA_W-1:0] fetch_data_next,
    output logic              cpu_hold,
    output logic              load_done,
    output logic              cs_err
);

    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

    state_t            state, state_nx;
    logic [ADDR_W:0]   wr_ptr;
    logic [ADDR_W:0]   len;
    logic [ADDR_W:0]   len_clamped;
    logic              start;
    logic              mem_we;
    logic [DATA_W-1:0] mem_wdata;
    logic              load_done_q;
    state_t            after_data;

    assign len_clamped = (load_len > DEPTH_L) ? DEPTH_L : load_len;
    assign after_data  = (len == DEPTH_L) ? ST_RUN : ST_FILL;

`ifdef PROGMEM_CHECKSUM_EN
    logic [DATA_W-1:0] cs_acc;
    logic [DATA_W-1:0] cs_sum;
    logic              cs_fail;
    logic              cs_err_q;

    assign cs_sum = cs_acc + ld_data;
`endif

    // Next-state and control decode; ld_ready depends on state only.
    always_comb begin
        state_nx  = state;
        ld_ready  = 1'b0;
        start     = 1'b0;
        mem_we    = 1'b0;
        mem_wdata = ld_data;
`ifdef PROGMEM_CHECKSUM_EN
        cs_fail   = 1'b0;
`endif
        case (state)
            ST_EMPTY, ST_RUN: begin
                if (load_start) begin
                    start    = 1'b1;
                    state_nx = (len_clamped == '0) ? ST_FILL : ST_LOAD;
                end
            end
            ST_LOAD: begin
                ld_ready = 1'b1;
                if (ld_valid) begin
                    mem_we = 1'b1;
                    if (wr_ptr == len - 1'b1) begin
`ifdef PROGMEM_CHECKSUM_EN
                        state_nx = ST_CHECK;
`else
                        state_nx = after_data;
`endif
                    end
                end
            end
`ifdef PROGMEM_CHECKSUM_EN
            ST_CHECK: begin
                ld_ready = 1'b1;
                if (ld_valid) begin
                    if (cs_sum == '0) begin
                        state_nx = after_data;
                    end else begin
                        cs_fail  = 1'b1;
                        state_nx = ST_EMPTY;
                    end
                end
            end
`endif
            ST_FILL: begin
                mem_we    = 1'b1;
                mem_wdata = NOP_WORD;
                if (wr_ptr == DEPTH_L - 1'b1) begin
                    state_nx = ST_RUN;
                end
            end
            default: state_nx = ST_EMPTY;
        endcase
    end

    // State, write pointer, latched length and the completion pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_EMPTY;
            wr_ptr      <= '0;
            len         <= '0;
            load_done_q <= 1'b0;
        end else begin
            state       <= state_nx;
            load_done_q <= (state_nx == ST_RUN) && (state != ST_RUN);
            if (start) begin
                wr_ptr <= '0;
                len    <= len_clamped;
            end else if (mem_we) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
        end
    end

`ifdef PROGMEM_CHECKSUM_EN
    // Running byte sum of the program and sticky mismatch flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            cs_acc   <= '0;
            cs_err_q <= 1'b0;
        end else if (start) begin
            cs_acc   <= '0;
            cs_err_q <= 1'b0;
        end else begin
            if ((state == ST_LOAD) && ld_valid) begin
                cs_acc <= cs_sum;
            end
            if (cs_fail) begin
                cs_err_q <= 1'b1;
            end
        end
    end

    assign cs_err = cs_err_q;
`else
    assign cs_err = 1'b0;
`endif

    assign cpu_hold  = (state != ST_RUN);
    assign load_done = load_done_q;

    prog_mem_array #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) u_array (
        .clk        (clk),
        .we         (mem_we),
        .waddr      (wr_ptr[ADDR_W-1:0]),
        .wdata      (mem_wdata),
        .raddr      (fetch_addr),
        .rdata      (fetch_data),
        .rdata_next (fetch_data_next)
    );

endmodule

// File: tb/tb_prog_mem_loader.sv
// Bench for prog_mem_loader: directed and randomized loads checked against a
// word-array reference model of the program memory.
module tb_prog_mem_loader;
    import prog_mem_pkg::*;

    localparam int DEPTH = 256;
`ifdef PROGMEM_CHECKSUM_EN
    localparam bit CS_EN = 1'b1;
`else
    localparam bit CS_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic       load_start;
    logic [8:0] load_len;
    logic       ld_valid;
    logic [7:0] ld_data;
    logic       ld_ready;
    logic [7:0] fetch_addr;
    logic [7:0] fetch_data;
    logic [7:0] fetch_data_next;
    logic       cpu_hold;
    logic       load_done;
    logic       cs_err;

    logic [7:0] mdl [DEPTH];
    logic [7:0] src [DEPTH];
    int n_chk  = 0;
    int n_pass = 0;

    prog_mem_loader dut (
        .clk             (clk),
        .reset           (reset),
        .load_start      (load_start),
        .load_len        (load_len),
        .ld_valid        (ld_valid),
        .ld_data         (ld_data),
        .ld_ready        (ld_ready),
        .fetch_addr      (fetch_addr),
        .fetch_data      (fetch_data),
        .fetch_data_next (fetch_data_next),
        .cpu_hold        (cpu_hold),
        .load_done       (load_done),
        .cs_err          (cs_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic sweep(input string tag);
        for (int a = 0; a < DEPTH; a++) begin
            fetch_addr = 8'(a);
            #1;
            chk({tag, "_data"}, fetch_data, mdl[a]);
            chk({tag, "_next"}, fetch_data_next, mdl[(a + 1) % DEPTH]);
        end
    endtask

    // bp: 0 = always valid, 1 = valid every other cycle, 2 = random
    task automatic do_load(input int req_len, input int bp, input bit cs_good, input bit stray);
        int L, n, idle, sent, to_send, hold_err, rdy_err, guard, k;
        logic [7:0] sum, cs_byte;
        bit v;
        L = (req_len > DEPTH) ? DEPTH : req_len;
        to_send = L + ((L > 0 && CS_EN) ? 1 : 0);
        sum = 8'h00;
        for (int i = 0; i < L; i++) sum = sum + src[i];
        cs_byte = cs_good ? (8'h00 - sum) : (8'h01 - sum);
        n = 0; idle = 0; sent = 0; hold_err = 0; rdy_err = 0; guard = 0; k = 0;

        load_start = 1'b1;
        load_len   = 9'(req_len);
        tick();
        load_start = 1'b0;
        n = 1;
        chk("cs_err_clear_on_start", cs_err, 0);

        while (sent < to_send && guard < 2000) begin
            if (ld_ready !== 1'b1) rdy_err++;
            if (cpu_hold !== 1'b1) hold_err++;
            case (bp)
                0:       v = 1'b1;
                1:       v = (k % 2 == 0);
                default: v = 1'(($urandom_range(0, 1)));
            endcase
            ld_valid   = v;
            ld_data    = (sent < L) ? src[sent] : cs_byte;
            load_start = stray && ($urandom_range(0, 3) == 0);
            load_len   = 9'($urandom_range(0, 511));
            tick();
            n++; guard++; k++;
            if (v) begin
                if (sent < L) mdl[sent] = src[sent];
                sent++;
            end else begin
                idle++;
            end
        end
        ld_valid   = 1'b0;
        load_start = 1'b0;
        chk("load_bounded", guard >= 2000, 0);
        chk("ready_in_load", rdy_err, 0);

        if (CS_EN && L > 0 && !cs_good) begin
            chk("cs_err_set", cs_err, 1);
            chk("bad_cs_hold", cpu_hold, 1);
            chk("bad_cs_ready", ld_ready, 0);
            k = 0;
            for (int i = 0; i < 4; i++) begin
                if (load_done !== 1'b0 || cpu_hold !== 1'b1) k++;
                tick();
            end
            chk("bad_cs_no_done", k, 0);
            chk("bad_cs_sticky", cs_err, 1);
            return;
        end

        guard = 0;
        while (load_done !== 1'b1 && guard < 2000) begin
            if (cpu_hold !== 1'b1) hold_err++;
            if (ld_ready !== 1'b0) rdy_err++;
            load_start = stray && ($urandom_range(0, 3) == 0);
            load_len   = 9'($urandom_range(0, 511));
            tick();
            n++; guard++;
        end
        load_start = 1'b0;
        for (int i = L; i < DEPTH; i++) mdl[i] = OP_NOP;

        chk("latency", n, 1 + to_send + idle + (DEPTH - L));
        chk("hold_during_load", hold_err, 0);
        chk("ready_in_fill", rdy_err, 0);
        chk("hold_at_done", cpu_hold, 0);
        chk("cs_err_after_good", cs_err, 0);
        tick();
        chk("done_one_cycle", load_done, 0);
        chk("run_hold", cpu_hold, 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        reset = 1'b1; load_start = 1'b0; load_len = '0;
        ld_valid = 1'b0; ld_data = '0; fetch_addr = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_hold", cpu_hold, 1);
        chk("rst_ready", ld_ready, 0);
        chk("rst_done", load_done, 0);
        chk("rst_cs_err", cs_err, 0);
        reset = 1'b0;
        repeat (3) tick();
        chk("idle_hold", cpu_hold, 1);
        chk("idle_ready", ld_ready, 0);

        // load_start with no data stays in LOAD
        load_start = 1'b1; load_len = 9'd5;
        tick();
        load_start = 1'b0;
        repeat (3) tick();
        chk("stall_ready", ld_ready, 1);
        chk("stall_hold", cpu_hold, 1);
        do_reset();

        // 30-byte averaging program
        src[0]  = OP_MOV_IMM; src[1]  = 8'h04; src[2]  = OP_MOV_IMM; src[3]  = 8'h00;
        src[4]  = OP_ADD;     src[5]  = 8'h20; src[6]  = OP_INC;     src[7]  = OP_CMP_IMM;
        src[8]  = 8'h04;      src[9]  = OP_BEQ; src[10] = 8'h0D;     src[11] = OP_BRA;
        src[12] = 8'h04;      src[13] = OP_SHR; src[14] = OP_SHR;    src[15] = OP_HLT;
        for (int i = 16; i < 30; i++) src[i] = 8'(8'h21 + i);
        do_load(30, 0, 1'b1, 1'b0);
        fetch_addr = 8'd4;   #1; chk("avg_f4", fetch_data, 8'h98);
        fetch_addr = 8'd0;   #1; chk("avg_f0_next", fetch_data_next, 8'h04);
        fetch_addr = 8'd200; #1; chk("avg_f200", fetch_data, 8'h70);
        sweep("avg");

        // backpressure: valid every other cycle
        for (int i = 0; i < DEPTH; i++) src[i] = 8'($urandom);
        do_load(10, 1, 1'b1, 1'b1);
        sweep("bp");

        // zero length: pure fill
        do_load(0, 0, 1'b1, 1'b1);
        sweep("len0");

        // oversize length clamps to DEPTH
        for (int i = 0; i < DEPTH; i++) src[i] = 8'($urandom);
        do_load(300, 0, 1'b1, 1'b0);
        fetch_addr = 8'd255; #1; chk("wrap_next", fetch_data_next, src[0]);
        sweep("len300");

        // reset after 5 bytes of a 20-byte load
        load_start = 1'b1; load_len = 9'd20;
        tick();
        load_start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            ld_valid = 1'b1; ld_data = 8'($urandom);
            mdl[i] = ld_data;
            tick();
        end
        ld_valid = 1'b0;
        reset = 1'b1;
        tick();
        chk("midrst_hold", cpu_hold, 1);
        chk("midrst_ready", ld_ready, 0);
        reset = 1'b0;
        for (int i = 0; i < DEPTH; i++) src[i] = 8'($urandom);
        do_load(256, 2, 1'b1, 1'b1);
        sweep("after_rst");

        // randomized reloads from RUN
        for (int r = 0; r < 6; r++) begin
            for (int i = 0; i < DEPTH; i++) src[i] = 8'($urandom);
            do_load($urandom_range(0, 300), $urandom_range(0, 2), 1'b1, 1'b1);
            sweep("rand");
        end

`ifdef PROGMEM_CHECKSUM_EN
        src[0] = 8'h01; src[1] = 8'h02; src[2] = 8'h03;
        do_load(3, 0, 1'b1, 1'b0);
        sweep("cs_good");
        do_load(3, 0, 1'b0, 1'b0);
        for (int i = 0; i < DEPTH; i++) src[i] = 8'($urandom);
        do_load($urandom_range(1, 200), 2, 1'b1, 1'b0);
        sweep("cs_recover");
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/prog_mem_loader.md
# prog_mem_loader

Parametrised, runtime-loadable instruction memory for the 8-bit core. Replaces the hard-coded reset-time ROM image with a byte-serial load port (valid/ready), back-fills unused words with NOP, and holds the CPU until a complete program is in place. It exposes two combinational fetch ports (opcode byte and following byte), so two-byte instructions fetch in one cycle.

## Interface
- DATA_W, 8, instruction byte width
- ADDR_W, 8, fetch/write address width
- DEPTH, 2**ADDR_W, number of words; must be ≤ 2**ADDR_W
- NOP_WORD, 8'h70, fill value written to words not covered by a load
- Reset: one clock; reset is synchronous and active-high.
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- load_start  in  1  one-cycle pulse that begins a load; sampled only in EMPTY or RUN
- load_len  in  ADDR_W+1  number of program bytes, sampled with load_start; values above DEPTH are clamped to DEPTH
- ld_valid  in  1  ld_data is valid
- ld_data  in  DATA_W  program byte
- ld_ready  out  1  block accepts a byte this cycle
- fetch_addr  in  ADDR_W  CPU fetch address
- fetch_data  out  DATA_W  mem[fetch_addr], combinational
- fetch_data_next  out  DATA_W  mem[(fetch_addr+1) mod DEPTH], combinational
- cpu_hold  out  1  CPU must stall while high
- load_done  out  1  one-cycle pulse when a load completes
- cs_err  out  1  checksum mismatch on the last load; sticky until the next load_start

## Operation
- States: EMPTY, LOAD, CHECK (only when the checksum feature is compiled in), FILL, RUN.
- EMPTY (reset state): cpu_hold=1, ld_ready=0. load_start moves to LOAD and sets wr_ptr=0; a clamped length of 0 goes straight to FILL.
- LOAD: ld_ready=1. A transfer (ld_valid&&ld_ready at posedge) writes mem[wr_ptr]=ld_data and increments wr_ptr.
  - The transfer at wr_ptr=len-1 moves to CHECK if checksum is enabled, otherwise to FILL.
  - If len=DEPTH, the next state is RUN instead of FILL.
- FILL: ld_ready=0. Writes NOP_WORD to mem[wr_ptr], one word per cycle, for wr_ptr=len..DEPTH-1, then moves to RUN.
- RUN: cpu_hold=0. load_start re-enters LOAD for a reload; cpu_hold rises the next cycle.
- load_start is ignored in LOAD, CHECK and FILL.
- Fetch reads are asynchronous from the array. A read of an address being written in the same cycle returns the old value.
- Reset mid-operation returns to EMPTY with cpu_hold=1. Memory contents are not cleared; wr_ptr and the checksum accumulator are zeroed.
- Array contents are undefined after power-up; no reset clearing of storage.

## Timing
- Reset values: ld_ready=0, cpu_hold=1, load_done=0, cs_err=0.
- ld_ready is a function of state only; it never depends on ld_valid.
- Maximum throughput is 1 byte per cycle.
- Load latency from load_start to RUN, with no backpressure and checksum disabled: 1 + len + (DEPTH−len) cycles.
- load_done is high for exactly the first cycle in RUN; cpu_hold is low in that same cycle.
- fetch_data and fetch_data_next are valid in the same cycle as fetch_addr (zero latency).

## Configuration
- PROGMEM_CHECKSUM_EN defined:
  - After len data bytes, CHECK accepts one more byte (ld_ready=1).
  - Pass condition: (sum of all data bytes + checksum byte) mod 2**DATA_W == 0. On pass, go to FILL (or to RUN if len=DEPTH).
  - On fail, set cs_err=1 and go to EMPTY; cpu_hold stays 1 and load_done does not pulse.
  - The checksum byte is not written to memory.
- PROGMEM_CHECKSUM_EN undefined: no CHECK state and no accumulator; cs_err is tied to 0.

## Structure
- Package prog_mem_pkg holds:
  - the state enum
  - default NOP_WORD
  - the core opcode constants (MOV_IMM, CMP_IMM, INC, BRA, BEQ, NOP, …), shared with the assembler-side test images
- Sub-module prog_mem_array holds the storage: DEPTH×DATA_W, one synchronous write port, two asynchronous read ports (the second address is wrapped modulo DEPTH).
- The FSM, wr_ptr and checksum logic live in prog_mem_loader.

## Test plan
- Reset, no stimulus: cpu_hold=1, ld_ready=0, load_done=0, cs_err=0; load_start with ld_valid=0 leaves the block in LOAD with hold=1.
- Load the 30-byte averaging program with load_len=30, DEPTH=256: 30 transfers, then 226 FILL cycles, then load_done pulse with cpu_hold=0. Expected reads:
  - fetch_addr=4 → fetch_data=8'h98
  - fetch_addr=0 → fetch_data_next=8'h04
  - fetch_addr=200 → fetch_data=8'h70
- Backpressure: ld_valid toggled every other cycle on a 10-byte load → exactly 10 writes, wr_ptr stalls on idle cycles, contents match the input order.
- load_len=0 → 256 FILL cycles, every word reads 8'h70; load_len=300 → clamped to 256 with no FILL; fetch_addr=255 → fetch_data_next=mem[0].
- Reset asserted after 5 bytes of a 20-byte load → next cycle cpu_hold=1, ld_ready=0; a new full load then completes normally.
- With PROGMEM_CHECKSUM_EN, bytes {01,02,03}:
  - checksum 8'hFA → load_done pulses, cs_err=0
  - checksum 8'hFB → cs_err=1, block in EMPTY, cpu_hold=1; the next load_start clears cs_err
